// File: rtl/rv_instr_encoder_loader.sv
// rv_instr_encoder_loader
//   Takes symbolic RV32I instruction fields over a valid/ready handshake and
//   encodes them as R-type, load, store or branch words. It buffers the words
//   in a small FIFO and writes them to consecutive instruction-memory word
//   addresses, stalling whenever the memory side is not ready.
//
// Parameters
//   DEPTH     FIFO entries (power of 2, >= 2)
//   ADDR_W    instruction-memory word-address width
//   BASE_ADDR first word address written after start
//
// Ports
//   clk, reset_n          rising-edge clock, asynchronous active-low reset
//   start                 opens a load session (only honoured in IDLE)
//   in_valid/in_ready     field handshake
//   in_kind               00 R-type, 01 load, 10 store, 11 branch
//   in_rd/rs1/rs2         register indices
//   in_funct3/in_funct7   function fields (funct7 is used by R-type only)
//   in_imm                I/S immediate; branch byte offset bits [12:1]
//   in_last               final instruction of the session
//   imem_we/addr/wdata    instruction-memory write request
//   imem_ready            memory accepts the write this cycle
//   busy                  session active
//   done                  one-cycle pulse after the final word is written
//   overflow              sticky: write address wrapped during the session
//   words_written         writes in this session, saturating at all-ones
module rv_instr_encoder_loader #(
    parameter int DEPTH     = 4,
    parameter int ADDR_W    = 8,
    parameter int BASE_ADDR = 0
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              start,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [1:0]        in_kind,
    input  logic [4:0]        in_rd,
    input  logic [4:0]        in_rs1,
    input  logic [4:0]        in_rs2,
    input  logic [2:0]        in_funct3,
    input  logic [6:0]        in_funct7,
    input  logic [11:0]       in_imm,
    input  logic              in_last,
    output logic              imem_we,
    output logic [ADDR_W-1:0] imem_addr,
    output logic [31:0]       imem_wdata,
    input  logic              imem_ready,
    output logic              busy,
    output logic              done,
    output logic              overflow,
    output logic [ADDR_W:0]   words_written
);

    localparam int                PTR_W  = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [ADDR_W-1:0] BASE   = ADDR_W'(BASE_ADDR);
    localparam logic [PTR_W:0]    FULL   = (PTR_W + 1)'(DEPTH);
    localparam logic [PTR_W:0]    ONE    = (PTR_W + 1)'(1);
    localparam logic [ADDR_W:0]   WW_MAX = '1;

    localparam logic [6:0] OP_R      = 7'b0110011;
    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        DRAIN = 2'd2
    } state_t;

    state_t state, state_nxt;

    logic [31:0]      fifo_mem [DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic [PTR_W:0]   count;

    logic push;
    logic pop;
    logic start_sess;
    logic drain_done;

    // For branches in_imm holds offset[12:1], so imm[11] is offset bit 12 and
    // imm[10] is offset bit 11, which lands in instruction bit 7.
    function automatic logic [31:0] encode(
        input logic [1:0]  kind,
        input logic [4:0]  rd,
        input logic [4:0]  rs1,
        input logic [4:0]  rs2,
        input logic [2:0]  funct3,
        input logic [6:0]  funct7,
        input logic [11:0] imm
    );
        logic [31:0] word;
        word = '0;
        case (kind)
            2'b00:   word = {funct7, rs2, rs1, funct3, rd, OP_R};
            2'b01:   word = {imm[11:0], rs1, funct3, rd, OP_LOAD};
            2'b10:   word = {imm[11:5], rs2, rs1, funct3, imm[4:0], OP_STORE};
            default: word = {imm[11], imm[9:4], rs2, rs1, funct3, imm[3:0], imm[10], OP_BRANCH};
        endcase
        return word;
    endfunction

    // All handshake and write-side outputs decode from registered state only.
    assign in_ready   = (state == RUN) && (count != FULL);
    assign imem_we    = (count != '0);
    assign imem_wdata = imem_we ? fifo_mem[rd_ptr] : 32'd0;
    assign busy       = (state != IDLE);

    assign push       = in_valid && in_ready;
    assign pop        = imem_we && imem_ready;
    assign start_sess = (state == IDLE) && start;
    // No pushes happen in DRAIN, so popping the only entry empties the FIFO.
    assign drain_done = (state == DRAIN) && pop && (count == ONE);

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (start) state_nxt = RUN;
            RUN:     if (push && in_last) state_nxt = DRAIN;
            DRAIN:   if (drain_done) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state         <= IDLE;
            wr_ptr        <= '0;
            rd_ptr        <= '0;
            count         <= '0;
            imem_addr     <= BASE;
            words_written <= '0;
            overflow      <= 1'b0;
            done          <= 1'b0;
        end else begin
            state <= state_nxt;
            done  <= drain_done;

            if (push) wr_ptr <= wr_ptr + 1'b1;
            if (pop)  rd_ptr <= rd_ptr + 1'b1;

            case ({push, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase

            if (start_sess) begin
                imem_addr     <= BASE;
                words_written <= '0;
                overflow      <= 1'b0;
            end else if (pop) begin
                imem_addr <= imem_addr + 1'b1;
                if (imem_addr == '1) overflow <= 1'b1;
                if (words_written != WW_MAX) words_written <= words_written + 1'b1;
            end
        end
    end

    // Word storage carries no reset; imem_wdata is masked while the FIFO is empty.
    always_ff @(posedge clk) begin
        if (push) begin
            fifo_mem[wr_ptr] <= encode(in_kind, in_rd, in_rs1, in_rs2,
                                       in_funct3, in_funct7, in_imm);
        end
    end

endmodule
